line_burst_mem_responder: RTL and testbench

- Memory-side responder for the cache line adapter's word-serial burst protocol.
- Receives one line request per transaction: a request strobe with read or write intent, plus a line address.
- Read: streams the 256-bit line as 8 consecutive 32-bit beats, word 0 first.
- Write: signals write-ready and captures 8 consecutive 32-bit beats into an internal word array.
- Serves as the simulation/FPGA backing store behind the cache.

---
 rtl/line_burst_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_line_burst_mem_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/line_burst_mem_responder.sv
// line_burst_mem_responder: memory-side responder for the cache line adapter's
// word-serial burst protocol. A line request is accepted in IDLE. After a
// programmable latency the responder either streams 8 read beats or captures
// 8 write beats, then pulses done for one cycle.
// Optional feature macro: BEAT_CHECKSUM_EN adds a 32-bit running-XOR checksum
// output over the 8 beats of each burst.
`timescale 1ns/1ps
module line_burst_mem_responder #(
  parameter int unsigned LINE_ADDR_W = 8,
  parameter int unsigned LATENCY     = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   toggle,
  input  logic                   re,
  input  logic                   we,
  input  logic [LINE_ADDR_W-1:0] addr,
  input  logic [31:0]            memDataOut,
  output logic [31:0]            memDataIn,
  output logic                   memValid,
  output logic                   busy,
  output logic                   done
`ifdef BEAT_CHECKSUM_EN
  , output logic [31:0]          checksum
`endif
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BEAT_W = 3;
  localparam int unsigned LAT_W  = 4;
  localparam int unsigned IDX_W  = LINE_ADDR_W + BEAT_W;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAT,
    S_RBURST,
    S_WBURST,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_op_wr;
  logic [LAT_W-1:0]       r_lat;
  logic [BEAT_W-1:0]      r_beat;
  logic [LINE_ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0]      r_data;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_done;
  logic [WORD_W-1:0]      r_mem [DEPTH];

  logic [BEAT_W-1:0]      w_beat_inc;
  logic [IDX_W-1:0]       w_widx;
  logic [WORD_W-1:0]      w_rd_first;
  logic [WORD_W-1:0]      w_rd_next;

  assign w_beat_inc = BEAT_W'(r_beat + BEAT_W'(1));
  assign w_widx     = {r_addr, r_beat};
  assign w_rd_first = r_mem[{r_addr, BEAT_W'(0)}];
  assign w_rd_next  = r_mem[{r_addr, w_beat_inc}];

  assign memDataIn = r_data;
  assign memValid  = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef BEAT_CHECKSUM_EN
  logic [WORD_W-1:0] r_xor;
  logic [WORD_W-1:0] r_checksum;
  logic [WORD_W-1:0] w_xor_next;

  // Fold the beat on the bus this cycle into the running XOR
  assign w_xor_next = r_xor ^ ((r_state == S_RBURST) ? r_data : memDataOut);
  assign checksum   = r_checksum;
`endif

  // Backing store: no reset so contents survive RST; a reset mid-burst
  // forces IDLE asynchronously, which stops further writes
  always_ff @(posedge CLK) begin
    if (r_state == S_WBURST) begin
      r_mem[w_widx] <= memDataOut;
    end
  end

  // Transaction FSM with registered beat/handshake outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_op_wr <= 1'b0;
      r_lat   <= '0;
      r_beat  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef BEAT_CHECKSUM_EN
      r_xor      <= '0;
      r_checksum <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (toggle && (re || we)) begin
            r_addr  <= addr;
            r_op_wr <= ~re;
            r_lat   <= LAT_W'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= S_LAT;
`ifdef BEAT_CHECKSUM_EN
            r_xor   <= '0;
`endif
          end
        end
        S_LAT: begin
          if (r_lat == '0) begin
            r_beat  <= '0;
            r_valid <= 1'b1;
            if (r_op_wr) begin
              r_data  <= '0;
              r_state <= S_WBURST;
            end else begin
              r_data  <= w_rd_first;
              r_state <= S_RBURST;
            end
          end else begin
            r_lat <= LAT_W'(r_lat - LAT_W'(1));
          end
        end
        S_RBURST, S_WBURST: begin
`ifdef BEAT_CHECKSUM_EN
          r_xor <= w_xor_next;
`endif
          if (r_beat == BEAT_W'(7)) begin
            r_beat  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
`ifdef BEAT_CHECKSUM_EN
            r_checksum <= w_xor_next;
`endif
          end else begin
            r_beat <= w_beat_inc;
            if (r_state == S_RBURST) begin
              r_data <= w_rd_next;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_mem_responder.sv
// Directed testbench for line_burst_mem_responder (LATENCY=3, LINE_ADDR_W=8).
// Cycle 0 is the toggle cycle; every step samples and drives 1 time unit after
// the rising edge.
`timescale 1ns/1ps
module tb_line_burst_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        toggle;
  logic        re;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] memDataOut;
  logic [31:0] memDataIn;
  logic        memValid;
  logic        busy;
  logic        done;
`ifdef BEAT_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  line_burst_mem_responder #(.LINE_ADDR_W(8), .LATENCY(3)) dut (
    .CLK(CLK), .RST(RST), .toggle(toggle), .re(re), .we(we), .addr(addr),
    .memDataOut(memDataOut), .memDataIn(memDataIn), .memValid(memValid),
    .busy(busy), .done(done)
`ifdef BEAT_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Cycle 0: present the request; returns positioned in cycle 1
  task automatic start_req(input logic [7:0] a, input logic r, input logic w);
    toggle = 1'b1; re = r; we = w; addr = a;
    tick();
    toggle = 1'b0; re = 1'b0; we = 1'b0; addr = '0;
  endtask

  function automatic logic [31:0] line_xor(input logic [255:0] line);
    logic [31:0] x;
    x = '0;
    for (int b = 0; b < 8; b++) x ^= line[32*b +: 32];
    return x;
  endfunction

  // Full write burst; starts in an IDLE cycle, ends in the IDLE cycle after done
  task automatic wr_line(input logic [7:0] a, input logic [255:0] line);
    start_req(a, 1'b0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      check_val("wr_lat_valid", 32'(memValid), 32'd0);
      check_val("wr_lat_busy", 32'(busy), 32'd1);
      tick();
    end
    for (int b = 0; b < 8; b++) begin
      check_val("wr_beat_valid", 32'(memValid), 32'd1);
      check_val("wr_beat_done", 32'(done), 32'd0);
      memDataOut = line[32*b +: 32];
      tick();
    end
    memDataOut = '0;
    check_val("wr_done", 32'(done), 32'd1);
    check_val("wr_done_valid", 32'(memValid), 32'd0);
    check_val("wr_done_busy", 32'(busy), 32'd1);
`ifdef BEAT_CHECKSUM_EN
    check_val("wr_checksum", checksum, line_xor(line));
`endif
    tick();
    check_val("wr_idle_busy", 32'(busy), 32'd0);
    check_val("wr_idle_done", 32'(done), 32'd0);
  endtask

  // Read burst; noise injects ignored requests in LAT and mid-burst
  task automatic rd_line(input logic [7:0] a, input logic r, input logic w,
                         input logic [255:0] exp, input logic noise, input logic [31:0] junk);
    start_req(a, r, w);
    memDataOut = junk;
    for (int c = 1; c <= 3; c++) begin
      toggle = noise && (c == 2); we = toggle; addr = toggle ? 8'h77 : 8'h00;
      check_val("rd_lat_valid", 32'(memValid), 32'd0);
      check_val("rd_lat_data", memDataIn, 32'd0);
      check_val("rd_lat_busy", 32'(busy), 32'd1);
      tick();
    end
    for (int b = 0; b < 8; b++) begin
      toggle = noise && (b == 2); re = toggle; addr = toggle ? 8'h77 : 8'h00;
      check_val("rd_beat_valid", 32'(memValid), 32'd1);
      check_val("rd_beat_data", memDataIn, exp[32*b +: 32]);
      check_val("rd_beat_done", 32'(done), 32'd0);
      tick();
    end
    toggle = 1'b0; re = 1'b0; we = 1'b0; addr = '0; memDataOut = '0;
    check_val("rd_done", 32'(done), 32'd1);
    check_val("rd_done_valid", 32'(memValid), 32'd0);
    check_val("rd_done_data", memDataIn, 32'd0);
`ifdef BEAT_CHECKSUM_EN
    check_val("rd_checksum", checksum, line_xor(exp));
`endif
    tick();
    check_val("rd_idle_busy", 32'(busy), 32'd0);
    check_val("rd_idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l5;
    logic [255:0] l6_abort;
    for (int b = 0; b < 8; b++) begin
      l5[32*b +: 32]       = 32'h11111111 * 32'(b + 1);
      l6_abort[32*b +: 32] = (b < 4) ? (32'hA0000000 + 32'(b)) : 32'd0;
    end

    RST = 1'b1; toggle = 1'b0; re = 1'b0; we = 1'b0; addr = '0; memDataOut = '0;
    repeat (3) tick();
    check_val("rst_valid", 32'(memValid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    RST = 1'b0;

    // Idle after reset for 20 cycles
    for (int c = 0; c < 20; c++) begin
      tick();
      check_val("idle_valid", 32'(memValid), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd0);
      check_val("idle_done", 32'(done), 32'd0);
      check_val("idle_data", memDataIn, 32'd0);
    end

    // Request with neither re nor we is ignored
    toggle = 1'b1;
    tick();
    toggle = 1'b0;
    check_val("null_req_busy", 32'(busy), 32'd0);
    tick();
    check_val("null_req_busy2", 32'(busy), 32'd0);

    wr_line(8'h05, l5);
    rd_line(8'h05, 1'b1, 1'b0, l5, 1'b0, 32'h0);
    rd_line(8'h05, 1'b1, 1'b1, l5, 1'b0, 32'hDEADBEEF);
    rd_line(8'h05, 1'b1, 1'b0, l5, 1'b1, 32'hCAFEF00D);

    // Aborted write to 0x06: four beats land, then asynchronous reset
    wr_line(8'h06, 256'd0);
    start_req(8'h06, 1'b0, 1'b1);
    repeat (3) tick();
    for (int b = 0; b < 4; b++) begin
      memDataOut = 32'hA0000000 + 32'(b);
      tick();
    end
    memDataOut = 32'h55555555;
    check_val("abort_pre_valid", 32'(memValid), 32'd1);
    check_val("abort_pre_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    #1;
    check_val("abort_valid", 32'(memValid), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_data", memDataIn, 32'd0);
    tick();
    check_val("abort_hold_busy", 32'(busy), 32'd0);
    RST = 1'b0;
    memDataOut = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check_val("abort_no_done", 32'(done), 32'd0);
      check_val("abort_no_valid", 32'(memValid), 32'd0);
    end

    rd_line(8'h06, 1'b1, 1'b0, l6_abort, 1'b0, 32'h0);
    rd_line(8'h05, 1'b1, 1'b0, l5, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
